sequenciador_entrada: RTL and testbench

- Front-end sequencer that produces the `contador_entrada` / `entrada_botao` pair consumed by the ULA input-enable decoder.
- Conditions the raw pushbutton: synchronises it, debounces it and turns each press into a single-cycle pulse.
- Advances the 2-bit input phase counter (00 = A, 01 = B, 10 = op, 11 = execute).
- Holds operand A, operand B and the opcode in registers, and issues one execute pulse per completed sequence.

---
 rtl/ula_pkg.sv | 20 ++
 rtl/debounce_botao.sv | 57 +++++
 rtl/sequenciador_entrada.sv | 101 ++++++++++
 tb/tb_sequenciador_entrada.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// ============================================================================
// Module  : ula_pkg
// Brief   : Phase encoding and default widths shared by the ULA front end.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ula_pkg;

    localparam logic [1:0] FASE_A    = 2'b00;
    localparam logic [1:0] FASE_B    = 2'b01;
    localparam logic [1:0] FASE_OP   = 2'b10;
    localparam logic [1:0] FASE_EXEC = 2'b11;

    localparam int DATA_WIDTH_PADRAO = 8;
    localparam int OP_WIDTH_PADRAO   = 3;

endpackage

`default_nettype wire

// File: rtl/debounce_botao.sv
// ============================================================================
// Module  : debounce_botao
// Brief   : Two-flop synchroniser, debounce counter and registered press pulse.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_botao #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic botao_bruto,
    input  logic limpar,
    output logic pulso
);

    localparam logic [7:0] C_LIMITE = 8'(DEBOUNCE_CYCLES - 1);

    logic       r_s1;
    logic       r_s2;
    logic       r_db;
    logic [7:0] r_cnt;
    logic       r_pulso;

    // The pulse is produced at the same edge db rises, so it is visible in the
    // cycle right after the final mismatching edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_db    <= 1'b0;
            r_cnt   <= 8'd0;
            r_pulso <= 1'b0;
        end else begin
            r_s1    <= botao_bruto;
            r_s2    <= r_s1;
            r_pulso <= 1'b0;
            if (r_s2 != r_db) begin
                if (r_cnt == C_LIMITE) begin
                    r_db    <= r_s2;
                    r_cnt   <= 8'd0;
                    r_pulso <= r_s2 & ~limpar;
                end else begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end else begin
                r_cnt <= 8'd0;
            end
        end
    end

    assign pulso = r_pulso;

endmodule

`default_nettype wire

// File: rtl/sequenciador_entrada.sv
// ============================================================================
// Module  : sequenciador_entrada
// Brief   : Button-driven A / B / opcode / execute input sequencer for the ULA.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sequenciador_entrada
    import ula_pkg::*;
#(
    parameter int DATA_WIDTH      = DATA_WIDTH_PADRAO,
    parameter int OP_WIDTH        = OP_WIDTH_PADRAO,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  botao_bruto,
    input  logic                  limpar,
    input  logic [DATA_WIDTH-1:0] entrada_numero,
    input  logic [OP_WIDTH-1:0]   operacao,
    output logic [1:0]            contador_entrada,
    output logic                  entrada_botao,
    output logic [DATA_WIDTH-1:0] numero_a,
    output logic [DATA_WIDTH-1:0] numero_b,
    output logic [OP_WIDTH-1:0]   operacao_reg,
    output logic                  executar,
    output logic                  pronto
);

    logic                  w_pulso;
    logic [1:0]            r_contador;
    logic [DATA_WIDTH-1:0] r_numero_a;
    logic [DATA_WIDTH-1:0] r_numero_b;
    logic [OP_WIDTH-1:0]   r_operacao;
    logic                  r_executar;
    logic                  r_pronto;

    debounce_botao #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk         (clk),
        .rst_n       (rst_n),
        .botao_bruto (botao_bruto),
        .limpar      (limpar),
        .pulso       (w_pulso)
    );

    // The phase only moves at the end of the pulse cycle, so the decoder sees
    // the old phase paired with entrada_botao.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_contador <= FASE_A;
            r_numero_a <= '0;
            r_numero_b <= '0;
            r_operacao <= '0;
            r_executar <= 1'b0;
            r_pronto   <= 1'b0;
        end else begin
            r_executar <= 1'b0;
            if (limpar) begin
                r_contador <= FASE_A;
                r_numero_a <= '0;
                r_numero_b <= '0;
                r_operacao <= '0;
                r_pronto   <= 1'b0;
            end else if (w_pulso) begin
                case (r_contador)
                    FASE_A: begin
                        r_numero_a <= entrada_numero;
                        r_pronto   <= 1'b0;
                        r_contador <= FASE_B;
                    end
                    FASE_B: begin
                        r_numero_b <= entrada_numero;
                        r_contador <= FASE_OP;
                    end
                    FASE_OP: begin
                        r_operacao <= operacao;
                        r_contador <= FASE_EXEC;
                    end
                    default: begin
                        r_executar <= 1'b1;
                        r_pronto   <= 1'b1;
                        r_contador <= FASE_A;
                    end
                endcase
            end
        end
    end

    assign contador_entrada = r_contador;
    assign entrada_botao    = w_pulso;
    assign numero_a         = r_numero_a;
    assign numero_b         = r_numero_b;
    assign operacao_reg     = r_operacao;
    assign executar         = r_executar;
    assign pronto           = r_pronto;

endmodule

`default_nettype wire

// File: tb/tb_sequenciador_entrada.sv
// ============================================================================
// Module  : tb_sequenciador_entrada
// Brief   : Self-checking bench for the ULA input sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sequenciador_entrada;
    import ula_pkg::*;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       botao_bruto;
    logic       limpar;
    logic [7:0] entrada_numero;
    logic [2:0] operacao;
    logic [1:0] contador_entrada;
    logic       entrada_botao;
    logic [7:0] numero_a;
    logic [7:0] numero_b;
    logic [2:0] operacao_reg;
    logic       executar;
    logic       pronto;

    sequenciador_entrada #(
        .DATA_WIDTH      (8),
        .OP_WIDTH        (3),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .botao_bruto      (botao_bruto),
        .limpar           (limpar),
        .entrada_numero   (entrada_numero),
        .operacao         (operacao),
        .contador_entrada (contador_entrada),
        .entrada_botao    (entrada_botao),
        .numero_a         (numero_a),
        .numero_b         (numero_b),
        .operacao_reg     (operacao_reg),
        .executar         (executar),
        .pronto           (pronto)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Scoreboard: phase expected at each pulse, plus a reference of captured state
    logic [1:0] fila_fase[$];
    logic [1:0] m_fase;
    logic [7:0] m_a;
    logic [7:0] m_b;
    logic [2:0] m_op;
    logic       m_pronto;

    task automatic borda();
        @(posedge clk);
        #1;
    endtask

    task automatic modelo_zero();
        m_fase   = FASE_A;
        m_a      = 8'h00;
        m_b      = 8'h00;
        m_op     = 3'b000;
        m_pronto = 1'b0;
        fila_fase.delete();
    endtask

    task automatic aplica_reset();
        rst_n          = 1'b0;
        botao_bruto    = 1'b0;
        limpar         = 1'b0;
        entrada_numero = 8'h00;
        operacao       = 3'b000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        modelo_zero();
    endtask

    task automatic pressiona(input logic [7:0] num, input logic [2:0] op);
        bit         achou;
        bit         pulso_solto;
        int         lat;
        logic [1:0] esp_fase;
        logic       esp_exec;
        entrada_numero = num;
        operacao       = op;
        fila_fase.push_back(m_fase);
        botao_bruto = 1'b1;
        achou = 0;
        lat   = 0;
        for (int i = 0; i < 40 && !achou; i++) begin
            borda();
            if (entrada_botao) begin
                achou = 1;
                lat   = i;
            end
        end
        esp_fase = fila_fase.pop_front();
        total++;
        if (!achou) $display("FAIL press_timeout: got no pulse, expected pulse within 40 edges");
        else passed++;
        if (achou) begin
            total++;
            if (lat !== D + 1) $display("FAIL press_latency: got edge %0d, expected edge %0d", lat + 1, D + 2);
            else passed++;
            total++;
            if (contador_entrada !== esp_fase)
                $display("FAIL phase_at_pulse: got %b, expected %b", contador_entrada, esp_fase);
            else passed++;
            esp_exec = 1'b0;
            case (esp_fase)
                FASE_A:  begin m_a = num; m_pronto = 1'b0; end
                FASE_B:  m_b = num;
                FASE_OP: m_op = op;
                default: begin m_pronto = 1'b1; esp_exec = 1'b1; end
            endcase
            m_fase = 2'(esp_fase + 2'd1);
            borda();
            total++;
            if ({contador_entrada, numero_a, numero_b, operacao_reg, pronto, executar, entrada_botao} !==
                {m_fase, m_a, m_b, m_op, m_pronto, esp_exec, 1'b0})
                $display("FAIL capture: got ph=%b a=%h b=%h op=%b pr=%b ex=%b pulse=%b, expected ph=%b a=%h b=%h op=%b pr=%b ex=%b pulse=0",
                         contador_entrada, numero_a, numero_b, operacao_reg, pronto, executar, entrada_botao,
                         m_fase, m_a, m_b, m_op, m_pronto, esp_exec);
            else passed++;
            borda();
            total++;
            if (executar !== 1'b0) $display("FAIL exec_single: got %b, expected 0", executar);
            else passed++;
        end
        botao_bruto = 1'b0;
        pulso_solto = 0;
        repeat (2 * D + 4) begin
            borda();
            pulso_solto |= entrada_botao;
        end
        total++;
        if (pulso_solto) $display("FAIL release_pulse: got pulse on release, expected none");
        else passed++;
    endtask

    task automatic test_reset();
        aplica_reset();
        total++;
        if ({contador_entrada, entrada_botao, numero_a, numero_b, operacao_reg, executar, pronto} !== '0)
            $display("FAIL reset_state: got ph=%b pulse=%b a=%h b=%h op=%b ex=%b pr=%b, expected all 0",
                     contador_entrada, entrada_botao, numero_a, numero_b, operacao_reg, executar, pronto);
        else passed++;
        for (int e = 1; e <= 20; e++) begin
            borda();
            if (e == 9) botao_bruto = 1'b1;
            if (e >= 10) begin
                total++;
                if (entrada_botao !== (e == 15))
                    $display("FAIL latency_edge%0d: got pulse=%b, expected %b", e, entrada_botao, (e == 15));
                else passed++;
                if (e == 15) begin
                    total++;
                    if (contador_entrada !== FASE_A)
                        $display("FAIL latency_phase: got %b, expected 00", contador_entrada);
                    else passed++;
                end
            end
        end
    endtask

    task automatic test_glitches();
        bit viu = 0;
        aplica_reset();
        repeat (5) begin
            botao_bruto = 1'b1;
            repeat (3) begin borda(); viu |= entrada_botao; end
            botao_bruto = 1'b0;
            repeat (4) begin borda(); viu |= entrada_botao; end
        end
        repeat (4) begin borda(); viu |= entrada_botao; end
        total++;
        if (viu) $display("FAIL glitch_pulse: got pulse, expected none");
        else passed++;
        total++;
        if (contador_entrada !== FASE_A) $display("FAIL glitch_phase: got %b, expected 00", contador_entrada);
        else passed++;
    endtask

    task automatic test_sequencia_completa();
        pressiona(8'h2A, 3'b000);
        pressiona(8'h15, 3'b000);
        pressiona(8'h00, 3'b101);
        pressiona(8'h00, 3'b000);
        total++;
        if ({numero_a, numero_b, operacao_reg, pronto, contador_entrada} !== {8'h2A, 8'h15, 3'b101, 1'b1, 2'b00})
            $display("FAIL full_sequence: got a=%h b=%h op=%b pr=%b ph=%b, expected a=2a b=15 op=101 pr=1 ph=00",
                     numero_a, numero_b, operacao_reg, pronto, contador_entrada);
        else passed++;
    endtask

    task automatic test_proximo_a();
        pressiona(8'hFF, 3'b000);
        total++;
        if ({numero_a, pronto, numero_b, contador_entrada} !== {8'hFF, 1'b0, 8'h15, 2'b01})
            $display("FAIL next_a: got a=%h pr=%b b=%h ph=%b, expected a=ff pr=0 b=15 ph=01",
                     numero_a, pronto, numero_b, contador_entrada);
        else passed++;
    endtask

    task automatic test_limpar();
        bit achou = 0;
        bit viu   = 0;
        pressiona(8'h33, 3'b000);
        entrada_numero = 8'h5C;
        operacao       = 3'b110;
        botao_bruto    = 1'b1;
        for (int i = 0; i < 40 && !achou; i++) begin
            borda();
            if (entrada_botao) achou = 1;
        end
        limpar = 1'b1;
        total++;
        if (!achou || contador_entrada !== FASE_OP)
            $display("FAIL clear_setup: got pulse=%b ph=%b, expected pulse=1 ph=10", achou, contador_entrada);
        else passed++;
        borda();
        limpar = 1'b0;
        modelo_zero();
        total++;
        if ({contador_entrada, numero_a, numero_b, operacao_reg, pronto, executar} !== '0)
            $display("FAIL clear_state: got ph=%b a=%h b=%h op=%b pr=%b ex=%b, expected all 0",
                     contador_entrada, numero_a, numero_b, operacao_reg, pronto, executar);
        else passed++;
        repeat (12) begin borda(); viu |= entrada_botao | executar; end
        total++;
        if (viu) $display("FAIL clear_held: got pulse/exec while held, expected none");
        else passed++;
        botao_bruto = 1'b0;
        repeat (2 * D + 4) borda();
    endtask

    task automatic test_reset_meio();
        pressiona(8'h11, 3'b000);
        botao_bruto = 1'b1;
        repeat (3) borda();
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({contador_entrada, entrada_botao, numero_a, numero_b, operacao_reg, executar, pronto} !== '0)
            $display("FAIL async_reset: got ph=%b pulse=%b a=%h b=%h op=%b ex=%b pr=%b, expected all 0",
                     contador_entrada, entrada_botao, numero_a, numero_b, operacao_reg, executar, pronto);
        else passed++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        modelo_zero();
        for (int e = 1; e <= D + 3; e++) begin
            borda();
            if (e <= D + 2) begin
                total++;
                if (entrada_botao !== (e == D + 2))
                    $display("FAIL rst_relaunch_edge%0d: got pulse=%b, expected %b", e, entrada_botao, (e == D + 2));
                else passed++;
            end else begin
                total++;
                if ({numero_a, contador_entrada} !== {8'h11, 2'b01})
                    $display("FAIL rst_relaunch_capture: got a=%h ph=%b, expected a=11 ph=01", numero_a, contador_entrada);
                else passed++;
            end
        end
        botao_bruto = 1'b0;
        repeat (2 * D + 4) borda();
    endtask

    initial begin
        test_reset();
        test_glitches();
        test_sequencia_completa();
        test_proximo_a();
        test_limpar();
        test_reset_meio();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of run, expected finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
